multi_timer: RTL and testbench

- Parametrised multi-channel countdown timer, successor to the fixed 10 s/20 s timer.
- NUM_CH independent channels share one prescaler tick. Each channel has a run-time duration, one-shot or periodic mode, hold (pause) and cancel.
- Sits between the control FSMs and the system clock. Supplies single-cycle done pulses, busy flags and remaining-count readback for display.

---
 rtl/timer_pkg.sv | 17 +
 rtl/timer_channel.sv | 73 +++++++
 rtl/multi_timer.sv | 56 +++++
 tb/tb_multi_timer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel countdown timer: channel state
// encoding and the clock-rate constants used to derive prescaler settings.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } ch_state_t;

    localparam int CLK_HZ      = 100_000_000;
    localparam int CLK_DIV_MS  = CLK_HZ / 1000;
    localparam int CLK_DIV_S   = CLK_HZ;
    localparam int DEF_CNT_W   = 16;
    localparam int DEF_CLK_DIV = CLK_DIV_MS;

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: IDLE/RUN/PAUSE state, remaining count, latched
// duration and mode, registered done pulse and busy flag.
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             cancel,
    input  logic             hold,
    input  logic             periodic,
    input  logic [CNT_W-1:0] duration,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] remaining
);

    ch_state_t        state;
    logic [CNT_W-1:0] dur_lat;
    logic             per_lat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            dur_lat   <= '0;
            per_lat   <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (cancel) begin
                state     <= ST_IDLE;
                remaining <= '0;
                busy      <= 1'b0;
            end else if (start) begin
                if (duration == '0) begin
                    state     <= ST_IDLE;
                    remaining <= '0;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                end else begin
                    dur_lat   <= duration;
                    per_lat   <= periodic;
                    remaining <= duration;
                    state     <= hold ? ST_PAUSE : ST_RUN;
                    busy      <= 1'b1;
                end
            end else if (state != ST_IDLE) begin
                // hold is a level: the count runs on any tick seen while it is low
                state <= hold ? ST_PAUSE : ST_RUN;
                if (!hold && tick) begin
                    if (remaining == CNT_W'(1)) begin
                        done <= 1'b1;
                        if (per_lat) begin
                            remaining <= dur_lat;
                        end else begin
                            remaining <= '0;
                            state     <= ST_IDLE;
                            busy      <= 1'b0;
                        end
                    end else begin
                        remaining <= remaining - CNT_W'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/multi_timer.sv
// Multi-channel countdown timer: one free-running prescaler producing a shared
// tick, fanned out to NUM_CH independent timer_channel instances.
module multi_timer
    import timer_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int DIV_W   = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       start,
    input  logic [NUM_CH-1:0]       cancel,
    input  logic [NUM_CH-1:0]       hold,
    input  logic [NUM_CH-1:0]       periodic,
    input  logic [NUM_CH*CNT_W-1:0] duration,
    output logic [NUM_CH-1:0]       done,
    output logic [NUM_CH-1:0]       busy,
    output logic [NUM_CH*CNT_W-1:0] remaining
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            tick    <= (div_cnt == DIV_LAST);
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        timer_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .start    (start[i]),
            .cancel   (cancel[i]),
            .hold     (hold[i]),
            .periodic (periodic[i]),
            .duration (duration[i*CNT_W +: CNT_W]),
            .done     (done[i]),
            .busy     (busy[i]),
            .remaining(remaining[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_multi_timer.sv
// Bench for multi_timer: a CLK_DIV=1 instance tracked cycle by cycle by a
// behavioural model, plus a CLK_DIV=4 instance for prescaler and reset timing.
module tb_multi_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  start, cancel, hold, periodic;
    logic [63:0] duration;
    logic [3:0]  done, busy;
    logic [63:0] remaining;

    logic        rst4;
    logic [1:0]  start4, cancel4, hold4, periodic4;
    logic [15:0] duration4;
    logic [1:0]  done4, busy4;
    logic [15:0] remaining4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    multi_timer #(.NUM_CH(4), .CNT_W(16), .CLK_DIV(1), .DIV_W(1)) dut (
        .clk(clk), .rst(rst), .start(start), .cancel(cancel), .hold(hold),
        .periodic(periodic), .duration(duration), .done(done), .busy(busy),
        .remaining(remaining)
    );

    multi_timer #(.NUM_CH(2), .CNT_W(8), .CLK_DIV(4), .DIV_W(3)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .cancel(cancel4), .hold(hold4),
        .periodic(periodic4), .duration(duration4), .done(done4), .busy(busy4),
        .remaining(remaining4)
    );

    // Behavioural model: per channel an active flag, a count, and the latched
    // duration/mode; the tick is every clk once the first edge after reset has passed.
    logic [15:0] m_rem[4], m_dur[4];
    logic        m_act[4], m_per[4], m_done[4];
    logic        m_tick;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tick <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_rem[i] <= '0; m_dur[i] <= '0; m_act[i] <= 1'b0;
                m_per[i] <= 1'b0; m_done[i] <= 1'b0;
            end
        end else begin
            m_tick <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                m_done[i] <= 1'b0;
                if (cancel[i]) begin
                    m_act[i] <= 1'b0; m_rem[i] <= '0;
                end else if (start[i]) begin
                    if (duration[i*16 +: 16] == 16'd0) begin
                        m_act[i] <= 1'b0; m_rem[i] <= '0; m_done[i] <= 1'b1;
                    end else begin
                        m_dur[i] <= duration[i*16 +: 16];
                        m_per[i] <= periodic[i];
                        m_rem[i] <= duration[i*16 +: 16];
                        m_act[i] <= 1'b1;
                    end
                end else if (m_act[i] && !hold[i] && m_tick) begin
                    if (m_rem[i] == 16'd1) begin
                        m_done[i] <= 1'b1;
                        if (m_per[i]) m_rem[i] <= m_dur[i];
                        else begin m_rem[i] <= '0; m_act[i] <= 1'b0; end
                    end else begin
                        m_rem[i] <= m_rem[i] - 16'd1;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        logic [3:0]  md, mb;
        logic [63:0] mr;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            md[i] = m_done[i];
            mb[i] = m_act[i];
            mr[i*16 +: 16] = m_rem[i];
        end
        chk("model_done", done, md);
        chk("model_busy", busy, mb);
        chk("model_rem", remaining, mr);
    endtask

    task automatic cycle4();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        start = '0; cancel = '0; hold = '0; periodic = '0; duration = '0;
    endtask

    function automatic logic [15:0] rem(input int ch);
        return remaining[ch*16 +: 16];
    endfunction

    typedef struct {
        logic [3:0]  st, cn, pr;
        logic [15:0] d;
        int          ch;
        logic        e_done, e_busy;
        logic [15:0] e_rem;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input logic [3:0] st, input logic [3:0] cn, input logic [3:0] pr,
                        input logic [15:0] d, input int ch, input logic ed,
                        input logic eb, input logic [15:0] er);
        vec_t v;
        v.st = st; v.cn = cn; v.pr = pr; v.d = d; v.ch = ch;
        v.e_done = ed; v.e_busy = eb; v.e_rem = er;
        tbl.push_back(v);
    endtask

    initial begin
        int t;
        logic found, seen;

        rst = 1'b1; rst4 = 1'b1;
        idle_in();
        start4 = '0; cancel4 = '0; hold4 = '0; periodic4 = '0; duration4 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_done", done, 4'h0);
        chk("reset_busy", busy, 4'h0);
        chk("reset_rem", remaining, 64'h0);
        chk("reset4_out", {done4, busy4, remaining4}, 20'h0);
        rst = 1'b0; rst4 = 1'b0;
        cycle(); cycle();

        // One-shot ch0 D=5, then periodic ch1 D=3 over 10 ticks and a cancel.
        addv(4'h1, 4'h0, 4'h0, 16'd5, 0, 1'b0, 1'b1, 16'd5);
        for (int k = 4; k >= 1; k--) addv(4'h0, 4'h0, 4'h0, 16'd0, 0, 1'b0, 1'b1, 16'(k));
        addv(4'h0, 4'h0, 4'h0, 16'd0, 0, 1'b1, 1'b0, 16'd0);
        addv(4'h0, 4'h0, 4'h0, 16'd0, 0, 1'b0, 1'b0, 16'd0);
        addv(4'h2, 4'h0, 4'h2, 16'd3, 1, 1'b0, 1'b1, 16'd3);
        for (int k = 1; k <= 10; k++)
            addv(4'h0, 4'h0, 4'h0, 16'd0, 1, (k % 3 == 0), 1'b1,
                 (k % 3 == 0) ? 16'd3 : 16'(3 - (k % 3)));
        addv(4'h0, 4'h2, 4'h0, 16'd0, 1, 1'b0, 1'b0, 16'd0);
        addv(4'h0, 4'h0, 4'h0, 16'd0, 1, 1'b0, 1'b0, 16'd0);
        addv(4'h0, 4'h0, 4'h0, 16'd0, 1, 1'b0, 1'b0, 16'd0);

        for (int k = 0; k < tbl.size(); k++) begin
            start = tbl[k].st; cancel = tbl[k].cn; periodic = tbl[k].pr;
            duration = {4{tbl[k].d}};
            cycle();
            chk($sformatf("tbl%0d_done", k), done[tbl[k].ch], tbl[k].e_done);
            chk($sformatf("tbl%0d_busy", k), busy[tbl[k].ch], tbl[k].e_busy);
            chk($sformatf("tbl%0d_rem", k), rem(tbl[k].ch), tbl[k].e_rem);
        end
        idle_in();

        // Hold: ch2 D=6, hold for 4 clks after 2 ticks.
        start = 4'h4; duration = {4{16'd6}};
        cycle(); idle_in();
        cycle(); cycle();
        chk("hold_pre_rem", rem(2), 16'd4);
        hold = 4'h4;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk($sformatf("hold_frozen%0d", k), {busy[2], rem(2)}, {1'b1, 16'd4});
        end
        hold = 4'h0;
        t = 6; found = 1'b0;
        while (t < 30 && !found) begin cycle(); t++; found = done[2]; end
        chk("hold_latency", t, 10);

        // Restart at remaining=2 discards the count; then start+cancel together.
        start = 4'h8; duration = {4{16'd8}};
        cycle(); idle_in();
        repeat (6) cycle();
        chk("restart_pre_rem", rem(3), 16'd2);
        start = 4'h8; duration = {4{16'd4}};
        cycle(); idle_in();
        chk("restart_rem", {done[3], rem(3)}, {1'b0, 16'd4});
        t = 0; found = 1'b0;
        while (t < 30 && !found) begin cycle(); t++; found = done[3]; end
        chk("restart_latency", t, 4);
        start = 4'h8; duration = {4{16'd8}};
        cycle();
        cancel = 4'h8;
        cycle(); idle_in();
        chk("start_cancel", {done[3], busy[3], rem(3)}, {2'b00, 16'd0});
        cycle();
        chk("start_cancel_nodone", done[3], 1'b0);

        // Zero duration expires immediately; two channels expire together.
        start = 4'h1; duration = '0;
        cycle(); idle_in();
        chk("zero_done", {done[0], busy[0]}, 2'b10);
        cycle();
        chk("zero_after", {done[0], busy[0]}, 2'b00);
        start = 4'h6; duration = {4{16'd7}};
        cycle(); idle_in();
        t = 0; found = 1'b0;
        while (t < 30 && !found) begin cycle(); t++; found = done[1] | done[2]; end
        chk("simul_latency", t, 7);
        chk("simul_both", done[2:1], 2'b11);

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                start[i]    = ($urandom_range(0, 7) == 0);
                cancel[i]   = ($urandom_range(0, 19) == 0);
                periodic[i] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 9) == 0) hold[i] = ~hold[i];
                duration[i*16 +: 16] = 16'($urandom_range(0, 6));
            end
            cycle();
        end
        idle_in();
        cancel = 4'hf;
        cycle(); idle_in();

        // Prescaler CLK_DIV=4, D=3, started at different prescaler phases.
        for (int off = 0; off < 4; off++) begin
            repeat (off) cycle4();
            start4 = 2'b01; duration4 = {8'd0, 8'd3};
            cycle4();
            start4 = '0;
            t = 0; found = 1'b0;
            while (t < 40 && !found) begin cycle4(); t++; found = done4[0]; end
            chk($sformatf("psc_lat_off%0d", off), (t >= 9 && t <= 12), 1'b1);
        end

        // Reset mid-count clears everything asynchronously; no done afterwards.
        start4 = 2'b11; duration4 = {8'd200, 8'd3};
        cycle4();
        start4 = '0;
        repeat (3) cycle4();
        #2 rst4 = 1'b1;
        #1;
        chk("rst_async_out", {done4, busy4, remaining4}, 20'h0);
        @(negedge clk);
        rst4 = 1'b0;
        seen = 1'b0;
        repeat (20) begin cycle4(); seen = seen | (|done4) | (|busy4); end
        chk("rst_no_done", seen, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
